match_event_recorder: RTL and testbench

MATCH_EVENT_RECORDER -- requirements
Module: match_event_recorder

---
 rtl/match_event_recorder_pkg.sv | 22 ++
 rtl/match_event_recorder_evt_fifo.sv | 92 +++++++++
 rtl/match_event_recorder.sv | 115 +++++++++++
 tb/tb_match_event_recorder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/match_event_recorder_pkg.sv
// ---------------------------------------------------------------------------
// match_event_recorder_pkg
// Shared constants and types for the serial pattern detector and the match
// event recorder. Holds the default timestamp width, event FIFO depth and
// match counter width, plus the timestamp type built from the default width.
// ---------------------------------------------------------------------------
package match_event_recorder_pkg;

  // Default sizing shared by the detector and the recorder
  localparam int TS_W_DEF  = 16;
  localparam int DEPTH_DEF = 8;
  localparam int CNT_W_DEF = 16;

  // Timestamp as carried between detector and recorder at default width
  typedef logic [TS_W_DEF-1:0] ts_t;

  // Pointer index width for a power-of-two FIFO depth
  function automatic int ptrIndexWidth(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/match_event_recorder_evt_fifo.sv
// ---------------------------------------------------------------------------
// evt_fifo
// Synchronous show-ahead FIFO holding event timestamps. The head entry is
// always presented on rdata; a pop simply advances the read pointer.
// Pointers carry one extra bit so that full and empty can be told apart
// when the index bits are equal.
//
// Ports
//   clk    in   clock, all state updates on the rising edge
//   rstn   in   asynchronous active-low reset (clears pointers and memory)
//   clr    in   synchronous clear of both pointers, wins over push/pop
//   push   in   write wdata at the tail
//   pop    in   discard the head entry (ignored while empty)
//   wdata  in   W-bit entry to write
//   rdata  out  W-bit head entry
//   full   out  DEPTH entries held
//   empty  out  no entries held
//   count  out  occupancy, $clog2(DEPTH)+1 bits
// ---------------------------------------------------------------------------
module evt_fifo
  import match_event_recorder_pkg::*;
#(
  parameter int W     = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = ptrIndexWidth(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wrPtr_q, wrPtr_d;
  logic [AW:0]  rdPtr_q, rdPtr_d;
  logic         doPush;
  logic         doPop;

  // Status flags come straight from the pointers. A push into a full FIFO
  // is still accepted when the head leaves on the same edge, because the
  // freed slot is the very slot the write lands in.
  always_comb begin
    count  = wrPtr_q - rdPtr_q;
    empty  = (wrPtr_q == rdPtr_q);
    full   = (count == FULL_CNT);
    doPop  = pop & ~empty;
    doPush = push & (~full | doPop);
    rdata  = mem_q[rdPtr_q[AW-1:0]];
  end

  // Pointer next-state: clear wins, otherwise each pointer steps by one
  // on an accepted operation and wraps naturally through the extra bit.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (clr) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + PTR_ONE;
      if (doPop)  rdPtr_d = rdPtr_q + PTR_ONE;
    end
  end

  // Pointer and storage registers. Memory is zeroed on reset so the head
  // output is never X, even before anything has been written.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      if (doPush && !clr) begin
        mem_q[wrPtr_q[AW-1:0]] <= wdata;
      end
    end
  end

endmodule

// File: rtl/match_event_recorder.sv
// ---------------------------------------------------------------------------
// match_event_recorder
// Records a timestamp for every match pulse from the serial pattern
// detector while recording is enabled. Timestamps come from a free-running
// counter and are queued in a show-ahead FIFO for a downstream consumer.
// Also keeps a saturating count of recorded matches and a sticky flag for
// events dropped because the FIFO was full.
//
// Ports
//   clk        in   clock
//   rstn       in   asynchronous active-low reset
//   det        in   one match this cycle
//   en         in   recording enable, det ignored while low
//   clr        in   synchronous clear of counters, flags and FIFO
//   evt_valid  out  FIFO head holds an event
//   evt_ts     out  TS_W-bit timestamp of the head event
//   evt_ready  in   consumer accepts the head event
//   fill       out  FIFO occupancy, $clog2(DEPTH)+1 bits
//   match_cnt  out  CNT_W-bit matches since reset or clr (saturating)
//   ovf        out  sticky, an event was dropped
// ---------------------------------------------------------------------------
module match_event_recorder
  import match_event_recorder_pkg::*;
#(
  parameter int TS_W  = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     det,
  input  logic                     en,
  input  logic                     clr,
  output logic                     evt_valid,
  output logic [TS_W-1:0]          evt_ts,
  input  logic                     evt_ready,
  output logic [$clog2(DEPTH):0]   fill,
  output logic [CNT_W-1:0]         match_cnt,
  output logic                     ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [TS_W-1:0]  TS_ONE  = TS_W'(1);

  logic [TS_W-1:0]  tsCnt_q, tsCnt_d;
  logic [CNT_W-1:0] matchCnt_q, matchCnt_d;
  logic             ovf_q, ovf_d;
  logic             pushReq;
  logic             popReq;
  logic             fifoFull;
  logic             fifoEmpty;
  logic             dropEvt;

  // Gating in front of the FIFO. A clear in the same cycle suppresses the
  // push and pop entirely, so the event is neither stored nor counted. An
  // event is dropped only when the FIFO is full and the head is not
  // leaving on this edge.
  always_comb begin
    pushReq = det & en & ~clr;
    popReq  = evt_ready & ~clr;
    dropEvt = pushReq & fifoFull & ~(popReq & ~fifoEmpty);
  end

  evt_fifo #(
    .W     (TS_W),
    .DEPTH (DEPTH)
  ) u_evt_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (clr),
    .push  (pushReq),
    .pop   (popReq),
    .wdata (tsCnt_q),
    .rdata (evt_ts),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fill)
  );

  // Next-state for the timestamp counter, match counter and overflow flag.
  // The timestamp counter runs regardless of en and wraps naturally; the
  // match counter holds at its maximum instead of wrapping.
  always_comb begin
    tsCnt_d    = tsCnt_q + TS_ONE;
    matchCnt_d = matchCnt_q;
    ovf_d      = ovf_q | dropEvt;
    if (pushReq && (matchCnt_q != CNT_MAX)) begin
      matchCnt_d = matchCnt_q + CNT_ONE;
    end
    if (clr) begin
      tsCnt_d    = '0;
      matchCnt_d = '0;
      ovf_d      = 1'b0;
    end
  end

  // State registers for the recorder-level bookkeeping
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tsCnt_q    <= '0;
      matchCnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      tsCnt_q    <= tsCnt_d;
      matchCnt_q <= matchCnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign evt_valid = ~fifoEmpty;
  assign match_cnt = matchCnt_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_match_event_recorder.sv
// ---------------------------------------------------------------------------
// tb_match_event_recorder
// Directed bench for match_event_recorder built with a 4-bit timestamp and
// 4-bit match counter so wrap and saturation are reachable quickly.
// Expected timestamps are queued when a push is issued; a monitor pops and
// compares them whenever the DUT hands over its head event.
// ---------------------------------------------------------------------------
module tb_match_event_recorder;

  localparam int TS_W  = 4;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             det = 1'b0;
  logic             en = 1'b0;
  logic             clr = 1'b0;
  logic             evt_ready = 1'b0;
  logic             evt_valid;
  logic [TS_W-1:0]  evt_ts;
  logic [3:0]       fill;
  logic [CNT_W-1:0] match_cnt;
  logic             ovf;

  int compared = 0;
  int mismatched = 0;

  // Bench-side model of what the recorder should hold
  logic [TS_W-1:0] expQ[$];
  int              mTs = 0;
  int              mFill = 0;
  int              mCnt = 0;
  int              mOvf = 0;

  match_event_recorder #(
    .TS_W  (TS_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .det       (det),
    .en        (en),
    .clr       (clr),
    .evt_valid (evt_valid),
    .evt_ts    (evt_ts),
    .evt_ready (evt_ready),
    .fill      (fill),
    .match_cnt (match_cnt),
    .ovf       (ovf)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  // Watchdog so the run always ends on its own
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scoreboard monitor: a handover happens on the coming edge when the
  // head is valid and accepted, so compare it against the oldest expected
  // timestamp halfway through the cycle.
  always @(negedge clk) begin
    logic [TS_W-1:0] e;
    if (rstn && !clr && evt_valid && evt_ready) begin
      compared++;
      if (expQ.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL evt_ts_unexpected: actual=%0d required=no event", evt_ts);
      end else begin
        e = expQ.pop_front();
        if (evt_ts !== e) begin
          mismatched++;
          $display("[TB] FAIL evt_ts_order: actual=%0d required=%0d", evt_ts, e);
        end
      end
    end
  end

  // Compare one observed value against a bench-computed value
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, update the model for that cycle, then wait
  // for the edge ending it and step just past it.
  task automatic applyStimulus(input logic d, input logic e, input logic c, input logic r);
    logic popOk;
    det = d;
    en = e;
    clr = c;
    evt_ready = r;
    if (c) begin
      expQ.delete();
      mFill = 0;
      mCnt = 0;
      mOvf = 0;
      mTs = 0;
    end else begin
      popOk = r && (mFill != 0);
      if (d && e) begin
        if (mCnt != 15) mCnt++;
        if (mFill < DEPTH || popOk) begin
          expQ.push_back(mTs[TS_W-1:0]);
          mFill++;
        end else begin
          mOvf = 1;
        end
      end
      if (popOk) mFill--;
      mTs = (mTs + 1) % 16;
    end
    @(posedge clk);
    #1;
    det = 1'b0;
    en = 1'b0;
    clr = 1'b0;
    evt_ready = 1'b0;
  endtask

  // Hold reset across an edge and release it just after the next edge
  task automatic doReset();
    rstn = 1'b0;
    expQ.delete();
    mTs = 0;
    mFill = 0;
    mCnt = 0;
    mOvf = 0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    $display("[TB] start");

    // Reset state
    doReset();
    checkOutput("rst_evt_valid", evt_valid, 0);
    checkOutput("rst_evt_ts", evt_ts, 0);
    checkOutput("rst_fill", fill, 0);
    checkOutput("rst_match_cnt", match_cnt, 0);
    checkOutput("rst_ovf", ovf, 0);

    // Single event in cycle 5 after reset
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("single_evt_valid", evt_valid, 1);
    checkOutput("single_evt_ts", evt_ts, 5);
    checkOutput("single_match_cnt", match_cnt, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("single_drained_fill", fill, 0);

    // First cycle after reset records timestamp 0
    doReset();
    applyStimulus(1, 1, 0, 0);
    checkOutput("first_evt_ts", evt_ts, 0);
    applyStimulus(0, 0, 0, 1);

    // Nine pushes into an eight-deep FIFO with no pops
    doReset();
    for (int i = 0; i < 9; i++) applyStimulus(1, 1, 0, 0);
    checkOutput("ovf_fill", fill, 8);
    checkOutput("ovf_flag", ovf, 1);
    checkOutput("ovf_match_cnt", match_cnt, 9);
    checkOutput("ovf_head", evt_ts, 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 1);
    checkOutput("ovf_drain_fill", fill, 0);
    checkOutput("ovf_sticky", ovf, 1);

    // Full FIFO with simultaneous push and pop
    doReset();
    for (int i = 0; i < 8; i++) applyStimulus(1, 1, 0, 0);
    checkOutput("fullpop_pre_fill", fill, 8);
    applyStimulus(1, 1, 0, 1);
    checkOutput("fullpop_fill", fill, 8);
    checkOutput("fullpop_ovf", ovf, 0);
    checkOutput("fullpop_head", evt_ts, 1);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 1);
    checkOutput("fullpop_drain_fill", fill, mFill);

    // Enable gating, then clear colliding with a match
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0);
    checkOutput("gate_fill", fill, 0);
    checkOutput("gate_match_cnt", match_cnt, 9);
    applyStimulus(1, 1, 0, 0);
    checkOutput("gate_push_cnt", match_cnt, 10);
    applyStimulus(1, 1, 1, 0);
    checkOutput("clr_fill", fill, 0);
    checkOutput("clr_match_cnt", match_cnt, 0);
    checkOutput("clr_evt_valid", evt_valid, 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("clr_ts_restart", evt_ts, 0);
    applyStimulus(0, 0, 0, 1);

    // Timestamp wrap from 15 to 0
    applyStimulus(0, 0, 1, 0);
    for (int i = 0; i < 15; i++) applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("wrap_ts15", evt_ts, 15);
    applyStimulus(1, 1, 0, 0);
    checkOutput("wrap_fill", fill, 2);
    applyStimulus(0, 0, 0, 1);
    checkOutput("wrap_ts0", evt_ts, 0);
    applyStimulus(0, 0, 0, 1);

    // Match counter saturation with the consumer keeping up
    applyStimulus(0, 0, 1, 0);
    for (int i = 0; i < 20; i++) applyStimulus(1, 1, 0, 1);
    checkOutput("sat_match_cnt", match_cnt, 15);
    checkOutput("sat_fill", fill, 1);
    applyStimulus(0, 0, 0, 1);

    // Asynchronous reset between edges with three events queued
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0);
    checkOutput("async_pre_fill", fill, 3);
    checkOutput("async_pre_head", evt_ts, 2);
    #2;
    rstn = 1'b0;
    expQ.delete();
    mTs = 0;
    mFill = 0;
    mCnt = 0;
    mOvf = 0;
    #1;
    checkOutput("async_fill", fill, 0);
    checkOutput("async_evt_valid", evt_valid, 0);
    checkOutput("async_evt_ts", evt_ts, 0);
    checkOutput("async_match_cnt", match_cnt, 0);
    checkOutput("async_ovf", ovf, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    applyStimulus(1, 1, 0, 0);
    checkOutput("async_after_ts", evt_ts, 0);
    applyStimulus(0, 0, 0, 1);

    checkOutput("scoreboard_left", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
